// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//
// Fetch/decode front end for picoMips. Drives the program-memory address and
// decodes the 10-bit instruction ({opcode[9:4], imm[3:0]}) that the registered
// ROM returns one clock later. Implements the HEI stall: execution halts while
// the handshake switch equals imm[0] of an HEI instruction.
//
// Optional feature macro: SEQ_SW_SYNC_EN
//   defined   : SW8 passes through a two-flop synchroniser before use.
//   undefined : SW8 is used directly (synchronous sources only).
//
// Ports
//   Clock        in   system clock, rising edge
//   nReset       in   asynchronous active-low reset
//   Instruction  in   ROM data for the address driven in the previous cycle
//   SW8          in   handshake switch
//   Addr         out  program-memory address (combinational)
//   ExecValid    out  decoded controls valid and committing this cycle
//   ExecAddr     out  address of the instruction currently on Instruction
//   AluOp        out  00 PASS, 01 ADD, 10 MUL
//   SrcSel       out  00 switches, 01 register, 10 immediate
//   Imm          out  sign-extended Instruction[3:0]
//   RegIdx       out  Instruction[3:0]
//   AccWe        out  accumulator write enable
//   RegWe        out  register-file write enable
//   Stalled      out  HEI holding execution
//   IllegalOp    out  sticky: an undefined opcode has been executed
// -----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic [9:0]               Instruction,
  input  logic                     SW8,
  output logic [ADDR_W-1:0]        Addr,
  output logic                     ExecValid,
  output logic [ADDR_W-1:0]        ExecAddr,
  output logic [1:0]               AluOp,
  output logic [1:0]               SrcSel,
  output logic signed [DATA_W-1:0] Imm,
  output logic [3:0]               RegIdx,
  output logic                     AccWe,
  output logic                     RegWe,
  output logic                     Stalled,
  output logic                     IllegalOp
);

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_HEI  = 6'd1;
  localparam logic [5:0] OP_LS   = 6'd2;
  localparam logic [5:0] OP_LR   = 6'd3;
  localparam logic [5:0] OP_AR   = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_ADDR = 6'd6;
  localparam logic [5:0] OP_MULI = 6'd7;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_MUL  = 2'b10;

  localparam logic [1:0] SRC_SW  = 2'b00;
  localparam logic [1:0] SRC_REG = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [3:0] v);
    sext_imm = {{(DATA_W-4){v[3]}}, v};
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] exec_addr_q, exec_addr_d;
  logic [1:0]        state_q, state_d;
  logic              illegal_q, illegal_d;
  logic              sw;

`ifdef SEQ_SW_SYNC_EN
  logic sw_meta_q, sw_sync_q;

  // SW8 is asynchronous to Clock: two flops before it reaches the halt decode.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
    end else begin
      sw_meta_q <= SW8;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw = sw_sync_q;
`else
  assign sw = SW8;
`endif

  logic [5:0] op;
  logic [3:0] imm4;
  logic       running;
  logic       halt;

  assign op      = Instruction[9:4];
  assign imm4    = Instruction[3:0];
  assign running = (state_q != ST_BOOT);
  assign halt    = running && (op == OP_HEI) && (sw == imm4[0]);

  // Fetch control. During a halt the HEI word is refetched from its own
  // address so it reappears next cycle; on release PC is already pointing at
  // the successor, so no bubble is inserted.
  always_comb begin
    Addr        = pc_q;
    pc_d        = pc_q;
    exec_addr_d = exec_addr_q;
    state_d     = state_q;
    ExecValid   = 1'b0;
    Stalled     = 1'b0;
    if (!running) begin
      Addr        = pc_q;
      pc_d        = pc_q + ADDR_W'(1);
      exec_addr_d = pc_q;
      state_d     = ST_RUN;
    end else if (halt) begin
      Addr        = exec_addr_q;
      exec_addr_d = exec_addr_q;
      state_d     = ST_WAIT;
      Stalled     = 1'b1;
    end else begin
      Addr        = pc_q;
      pc_d        = pc_q + ADDR_W'(1);
      exec_addr_d = pc_q;
      state_d     = ST_RUN;
      ExecValid   = 1'b1;
    end
  end

  // Decode. Undefined opcodes fall through to the default and behave as NOP.
  always_comb begin
    AluOp  = ALU_PASS;
    SrcSel = SRC_SW;
    AccWe  = 1'b0;
    RegWe  = 1'b0;
    if (ExecValid) begin
      case (op)
        OP_LS:   begin SrcSel = SRC_SW;  AluOp = ALU_PASS; AccWe = 1'b1; end
        OP_LR:   begin SrcSel = SRC_REG; AluOp = ALU_PASS; AccWe = 1'b1; end
        OP_AR:   begin RegWe  = 1'b1; end
        OP_ADDI: begin SrcSel = SRC_IMM; AluOp = ALU_ADD;  AccWe = 1'b1; end
        OP_ADDR: begin SrcSel = SRC_REG; AluOp = ALU_ADD;  AccWe = 1'b1; end
        OP_MULI: begin SrcSel = SRC_IMM; AluOp = ALU_MUL;  AccWe = 1'b1; end
        default: begin end
      endcase
    end
  end

  assign illegal_d = illegal_q | (ExecValid && (op > OP_MULI));

  assign Imm       = sext_imm(imm4);
  assign RegIdx    = imm4;
  assign ExecAddr  = exec_addr_q;
  assign IllegalOp = illegal_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q        <= '0;
      exec_addr_q <= '0;
      state_q     <= ST_BOOT;
      illegal_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      exec_addr_q <= exec_addr_d;
      state_q     <= state_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule
